reaction_timer_ctrl: RTL and testbench

Control and measurement core of the reaction timer. After a start press it waits a pseudo-random delay, lights the stimulus LED, and counts elapsed milliseconds in four BCD digits until the stop press. The four digit outputs drive four `seg7` decoder instances directly. Every digit it emits is always in the range 0–9.

---
 rtl/reaction_timer_ctrl_pkg.sv | 25 ++
 rtl/bcd_counter4.sv | 74 +++++++
 rtl/reaction_timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction timer: state encodings, BCD digit
// constants and the stimulus-delay LFSR step function.
package reaction_timer_ctrl_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam int unsigned LFSR_W  = 11;
    localparam int unsigned WAIT_W  = 14;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 11'h001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_FOUL = 3'd4
    } state_e;

    // Fibonacci step for x^11 + x^9 + 1; a non-zero seed never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[10] ^ cur[8]};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four cascaded BCD digits counting 0000..9999, saturating at 9999.
// A clear request always beats an increment request in the same cycle.
module bcd_counter4
    import reaction_timer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] d3,
    output logic [BCD_W-1:0] d2,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d0,
    output logic             at_max
);

    logic [BCD_W-1:0] d3_q, d2_q, d1_q, d0_q;
    logic [BCD_W-1:0] d3_d, d2_d, d1_d, d0_d;

    assign at_max = (d3_q == BCD_MAX) && (d2_q == BCD_MAX) &&
                    (d1_q == BCD_MAX) && (d0_q == BCD_MAX);

    // Next digit values: clear, or ripple-carry increment unless saturated.
    always_comb begin
        d3_d = d3_q;
        d2_d = d2_q;
        d1_d = d1_q;
        d0_d = d0_q;
        if (clr) begin
            d3_d = '0;
            d2_d = '0;
            d1_d = '0;
            d0_d = '0;
        end else if (inc && !at_max) begin
            if (d0_q == BCD_MAX) begin
                d0_d = '0;
                if (d1_q == BCD_MAX) begin
                    d1_d = '0;
                    if (d2_q == BCD_MAX) begin
                        d2_d = '0;
                        d3_d = d3_q + 4'd1;
                    end else begin
                        d2_d = d2_q + 4'd1;
                    end
                end else begin
                    d1_d = d1_q + 4'd1;
                end
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d3_q <= '0;
            d2_q <= '0;
            d1_q <= '0;
            d0_q <= '0;
        end else begin
            d3_q <= d3_d;
            d2_q <= d2_d;
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign d3 = d3_q;
    assign d2 = d2_q;
    assign d1 = d1_q;
    assign d0 = d0_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer control: random pre-stimulus delay, stimulus lamp and a
// millisecond BCD measurement of the time until the stop press.
module reaction_timer_ctrl
    import reaction_timer_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned MIN_WAIT_MS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             stim_led,
    output logic [BCD_W-1:0] bcd3,
    output logic [BCD_W-1:0] bcd2,
    output logic [BCD_W-1:0] bcd1,
    output logic [BCD_W-1:0] bcd0,
    output logic             false_start,
    output logic             busy
);

    localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                start_q, stop_q;
    logic                start_rise_q, stop_rise_q;
    logic                tick;
    logic                cnt_clr, cnt_inc, cnt_at_max;

    assign tick = (presc_q == PRESC_LAST);

    // Input edge detection; the rise pulse is registered so the FSM reacts
    // one edge after the press is first sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            start_rise_q <= 1'b0;
            stop_rise_q  <= 1'b0;
        end else begin
            start_q      <= start;
            stop_q       <= stop;
            start_rise_q <= start & ~start_q;
            stop_rise_q  <= stop & ~stop_q;
        end
    end

    // Free-running delay source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // FSM next-state, wait countdown and digit counter controls.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (start_rise_q) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q);
                    cnt_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                // A stop press always fouls, even on the final tick.
                if (stop_rise_q) begin
                    state_d = ST_FOUL;
                    cnt_clr = 1'b1;
                end else if (tick) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Stop wins over a coincident tick, which is then not counted.
                if (stop_rise_q) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (cnt_at_max) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Millisecond prescaler; restarts on every state entry.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if ((state_d != state_q) || tick) begin
            presc_d = '0;
        end
    end

    // State, prescaler and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            wait_q  <= wait_d;
        end
    end

    bcd_counter4 u_bcd_counter4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .d3     (bcd3),
        .d2     (bcd2),
        .d1     (bcd1),
        .d0     (bcd0),
        .at_max (cnt_at_max)
    );

    assign stim_led    = (state_q == ST_RUN);
    assign false_start = (state_q == ST_FOUL);
    assign busy        = (state_q == ST_WAIT) || (state_q == ST_RUN);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a 4-cycle tick and 2 ms minimum wait.
module tb_reaction_timer_ctrl;

    localparam int unsigned TICK = 4;
    localparam int unsigned MINW = 2;

    typedef struct {
        string       name;
        bit          foul_first;
        bit          hold_start;
        bit          use_stop;
        int          ticks;
        int          offset;
        int          hold_cycles;
        logic [15:0] exp_dig;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        stim_led;
    logic        false_start;
    logic        busy;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [15:0] dig;
    logic [10:0] lfsr_m;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] res_q[$];
    int          stim_q[$];
    row_t        rows[3];
    row_t        after_reset;

    reaction_timer_ctrl #(
        .TICK_CYCLES (TICK),
        .MIN_WAIT_MS (MINW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .stim_led    (stim_led),
        .bcd3        (bcd3),
        .bcd2        (bcd2),
        .bcd1        (bcd1),
        .bcd0        (bcd0),
        .false_start (false_start),
        .busy        (busy)
    );

    assign dig = {bcd3, bcd2, bcd1, bcd0};

    always #5 clk = ~clk;

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; the LFSR model advances exactly when the DUT's does.
    task automatic step();
        @(posedge clk);
        if (rst_n) lfsr_m = {lfsr_m[9:0], lfsr_m[10] ^ lfsr_m[8]};
        #1;
    endtask

    task automatic press_start(input string tag, input bit expect_stim);
        logic [10:0] used;
        start = 1'b1;
        step();
        used = lfsr_m;  // value the DUT loads on the next edge
        step();
        start = 1'b0;
        if (expect_stim) stim_q.push_back(int'(MINW + used) * int'(TICK));
        check({tag, " busy after start"}, busy, 1);
        check({tag, " stim before delay"}, stim_led, 0);
        check({tag, " false_start after start"}, false_start, 0);
    endtask

    task automatic wait_stim(input string tag);
        int c;
        int exp;
        int limit;
        exp   = stim_q.pop_front();
        limit = int'(MINW + 2047) * int'(TICK) + 8;
        c = 0;
        while (!stim_led && c < limit) begin
            step();
            c++;
        end
        check({tag, " stim delay"}, c, exp);
        check({tag, " digits at stim"}, dig, 16'h0000);
    endtask

    task automatic do_row(input row_t r);
        int c;
        int stop_c;
        int t_done;
        if (r.foul_first) begin
            press_start({r.name, " pre"}, 1'b0);
            stop = 1'b1;
            step();
            step();
            check({r.name, " foul flag"}, false_start, 1);
            check({r.name, " foul busy"}, busy, 0);
            check({r.name, " foul stim"}, stim_led, 0);
            check({r.name, " foul digits"}, dig, 16'h0000);
            stop = 1'b0;
            step();
            step();
        end
        press_start(r.name, 1'b1);
        wait_stim(r.name);
        stop_c = r.ticks * int'(TICK) + r.offset;
        t_done = r.use_stop ? stop_c + 2 : r.ticks * int'(TICK);
        res_q.push_back(r.exp_dig);
        c = 0;
        while (busy && c < t_done + 8) begin
            step();
            c++;
            if (r.use_stop && c == stop_c) stop = 1'b1;
            if (r.hold_start && c == 10) start = 1'b1;
            if (r.hold_start && c == 20) begin
                check({r.name, " held start busy"}, busy, 1);
                check({r.name, " held start count"}, dig, 16'h0005);
            end
            if (!r.use_stop) begin
                if (c == 36)   check({r.name, " at 0009"}, dig, 16'h0009);
                if (c == 40)   check({r.name, " carry 0010"}, dig, 16'h0010);
                if (c == 3996) check({r.name, " at 0999"}, dig, 16'h0999);
                if (c == 4000) check({r.name, " carry 1000"}, dig, 16'h1000);
            end
        end
        stop = 1'b0;
        check({r.name, " done cycle"}, c, t_done);
        check({r.name, " stim off"}, stim_led, 0);
        check({r.name, " busy off"}, busy, 0);
        check({r.name, " result"}, dig, res_q.pop_front());
        if (r.hold_start) begin
            repeat (5) step();
            check({r.name, " no restart"}, busy, 0);
            check({r.name, " held result"}, dig, r.exp_dig);
            start = 1'b0;
            step();
        end
        if (r.hold_cycles > 0) begin
            repeat (r.hold_cycles) step();
            check({r.name, " hold digits"}, dig, r.exp_dig);
            check({r.name, " hold busy"}, busy, 0);
            check({r.name, " hold false_start"}, false_start, 0);
        end
    endtask

    initial begin
        rows[0]     = '{"stop37",    1'b0, 1'b0, 1'b1, 37,    0,  100, 16'h0037};
        rows[1]     = '{"stoptick41", 1'b0, 1'b1, 1'b1, 42,   -2,  0,   16'h0041};
        rows[2]     = '{"saturate",  1'b1, 1'b0, 1'b0, 10000, 0,  0,   16'h9999};
        after_reset = '{"postreset", 1'b0, 1'b0, 1'b1, 5,     0,  0,   16'h0005};

        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        lfsr_m = 11'h001;
        repeat (3) step();
        check("reset stim", stim_led, 0);
        check("reset busy", busy, 0);
        check("reset false_start", false_start, 0);
        check("reset digits", dig, 16'h0000);
        rst_n = 1'b1;
        step();
        step();

        // Stop press in IDLE is ignored.
        stop = 1'b1;
        repeat (3) step();
        stop = 1'b0;
        step();
        check("idle stop busy", busy, 0);
        check("idle stop false_start", false_start, 0);

        for (int i = 0; i < 3; i++) do_row(rows[i]);

        // Asynchronous reset in the middle of a measurement.
        press_start("midreset", 1'b1);
        wait_stim("midreset");
        repeat (80) step();
        check("midreset count before", dig, 16'h0020);
        rst_n  = 1'b0;
        lfsr_m = 11'h001;
        #1;
        check("midreset stim", stim_led, 0);
        check("midreset busy", busy, 0);
        check("midreset false_start", false_start, 0);
        check("midreset digits", dig, 16'h0000);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        do_row(after_reset);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
